// File: rtl/spi_master_bridge_pkg.sv
// Shared encodings for the Wishbone-to-SPI bridge: frame FSM states, byte-shifter
// phases and the command-byte layout.
package spi_master_bridge_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_ACK  = 3'd4;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_LEAD  = 2'd1;
  localparam logic [1:0] PH_SHIFT = 2'd2;
  localparam logic [1:0] PH_TRAIL = 2'd3;

  localparam logic [7:0] BIT_WE    = 8'h80;
  localparam logic [7:0] MASK_ADDR = 8'h7F;

  function automatic logic [7:0] cmd_byte(input logic we, input logic [7:0] addr);
    return (we ? BIT_WE : 8'h00) | (addr & MASK_ADDR);
  endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// One SPI byte: CLK_DIV lead, 8 bits MSB first (drive on sck rise, sample on fall),
// CLK_DIV trail; ss_n is low for exactly 18*CLK_DIV cycles from the start edge.
module spi_byte_xfer
  import spi_master_bridge_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       miso,
  output logic       done,
  output logic [7:0] rx,
  output logic       sck,
  output logic       ss_n,
  output logic       mosi
);

  localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

  logic [1:0] phase_q;
  logic [7:0] cnt_q;
  logic [3:0] half_q;
  logic [7:0] tx_q;
  logic [7:0] rx_q;
  logic       sck_q;
  logic       ss_n_q;
  logic       mosi_q;
  logic       cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= 8'd0;
      half_q  <= 4'd0;
      tx_q    <= 8'd0;
      rx_q    <= 8'd0;
      sck_q   <= 1'b0;
      ss_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (start) begin
            phase_q <= PH_LEAD;
            cnt_q   <= 8'd0;
            tx_q    <= tx;
            ss_n_q  <= 1'b0;
          end
        end
        PH_LEAD: begin
          if (cnt_last) begin
            phase_q <= PH_SHIFT;
            cnt_q   <= 8'd0;
            half_q  <= 4'd0;
            sck_q   <= 1'b1;
            mosi_q  <= tx_q[7];
            tx_q    <= {tx_q[6:0], 1'b0};
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        PH_SHIFT: begin
          if (cnt_last) begin
            cnt_q  <= 8'd0;
            half_q <= half_q + 4'd1;
            if (sck_q) begin
              sck_q <= 1'b0;
              rx_q  <= {rx_q[6:0], miso};
            end else if (half_q == 4'd15) begin
              phase_q <= PH_TRAIL;
            end else begin
              sck_q  <= 1'b1;
              mosi_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          if (cnt_last) begin
            phase_q <= PH_IDLE;
            cnt_q   <= 8'd0;
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  // Combinational so the frame FSM can chain the next phase on the same edge.
  assign done = (phase_q == PH_TRAIL) && cnt_last;
  assign rx   = rx_q;
  assign sck  = sck_q;
  assign ss_n = ss_n_q;
  assign mosi = mosi_q;

endmodule

// File: rtl/spi_master_bridge.sv
// Wishbone slave to SPI master bridge: each access is a command byte {we, addr[6:0]},
// an ss-high gap, then a data byte. Optional SPI_MASTER_LOOPBACK_EN adds loopback_i.
module spi_master_bridge
  import spi_master_bridge_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [7:0] wb_addr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  output logic       wb_ack_o,
  output logic       busy_o,
  output logic       spi_sck,
  output logic       spi_ss,
  output logic       spi_mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic       loopback_i,
`endif
  input  logic       spi_miso
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic        we_q;
  logic [7:0]  dat_q;
  logic [7:0]  rdat_q;
  logic        ack_q;
  logic [15:0] gap_q;
  logic        accept;
  logic        xfer_start;
  logic [7:0]  xfer_tx;
  logic        xfer_done;
  logic [7:0]  xfer_rx;
  logic        xfer_ss_n;
  logic        rx_in;

  // The ack cycle itself blocks acceptance so a stb still high on ack is not re-taken.
  assign accept = (state_q == ST_IDLE) && wb_stb_i && !ack_q;

  always_comb begin
    state_d    = state_q;
    xfer_start = 1'b0;
    xfer_tx    = cmd_byte(wb_we_i, wb_addr_i);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_CMD;
          xfer_start = 1'b1;
        end
      end
      ST_CMD:  if (xfer_done) state_d = ST_GAP;
      ST_GAP: begin
        xfer_tx = we_q ? dat_q : 8'h00;
        if (gap_q == GAP_LAST) begin
          state_d    = ST_DATA;
          xfer_start = 1'b1;
        end
      end
      ST_DATA: if (xfer_done) state_d = ST_ACK;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      dat_q   <= 8'h00;
      rdat_q  <= 8'h00;
      ack_q   <= 1'b0;
      gap_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= (state_q == ST_GAP) ? gap_q + 16'd1 : 16'd0;
      ack_q   <= (state_q == ST_ACK) && wb_stb_i;
      if (accept) begin
        we_q  <= wb_we_i;
        dat_q <= wb_dat_i;
      end
      if ((state_q == ST_DATA) && xfer_done && !we_q) rdat_q <= xfer_rx;
    end
  end

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_in  = loopback_i ? spi_mosi : spi_miso;
  assign spi_ss = xfer_ss_n | loopback_i;
`else
  assign rx_in  = spi_miso;
  assign spi_ss = xfer_ss_n;
`endif

  spi_byte_xfer #(
    .CLK_DIV(CLK_DIV)
  ) u_xfer (
    .clk  (wb_clk_i),
    .rst_n(wb_rst_i),
    .start(xfer_start),
    .tx   (xfer_tx),
    .miso (rx_in),
    .done (xfer_done),
    .rx   (xfer_rx),
    .sck  (spi_sck),
    .ss_n (xfer_ss_n),
    .mosi (spi_mosi)
  );

  assign wb_dat_o = rdat_q;
  assign wb_ack_o = ack_q;
  assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_master_bridge.sv
// Scoreboard bench for spi_master_bridge (CLK_DIV=2, GAP_CYC=4): expected MOSI bytes and
// acks are queued by the stimulus; monitors pop and compare as the DUT produces them.
module tb_spi_master_bridge;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned GAP_CYC = 4;
  localparam int unsigned LAT     = 36 * CLK_DIV + GAP_CYC + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdat = 8'h00;
  logic [7:0] rdat;
  logic       stb = 1'b0;
  logic       we = 1'b0;
  logic       ack;
  logic       busy;
  logic       sck;
  logic       ss;
  logic       mosi;
  logic       miso;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  typedef struct {
    logic [7:0] dat;
    int         cyc;
  } ack_t;

  ack_t       ack_exp[$];
  logic [7:0] mosi_exp[$];
  int         cyc = 0;
  int         passed = 0;
  int         total = 0;

  // SPI monitor / slave model state
  logic [3:0] nbits = 4'd0;
  logic [7:0] sh = 8'h00;
  int         byte_idx = 0;
  int         hi_cnt = 0;
  logic       ss_prev = 1'b1;
  logic       sck_prev = 1'b0;
  logic [7:0] slave_byte = 8'h3C;
  logic [2:0] midx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_bridge #(
    .CLK_DIV(CLK_DIV),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wb_addr_i(addr),
    .wb_dat_i (wdat),
    .wb_dat_o (rdat),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_ack_o (ack),
    .busy_o   (busy),
    .spi_sck  (sck),
    .spi_ss   (ss),
    .spi_mosi (mosi),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback_i(loopback),
`endif
    .spi_miso (miso)
  );

  // Slave drives bit (7 - falls seen so far); the master samples it on the next fall.
  assign midx = 3'd7 - nbits[2:0];
  assign miso = slave_byte[midx];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Ack monitor
  always @(negedge clk) begin : ack_mon
    ack_t e;
    if (rst_n && ack) begin
      if (ack_exp.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = ack_exp.pop_front();
        check("ack_cycle", cyc, e.cyc);
        check("ack_dat", {24'd0, rdat}, {24'd0, e.dat});
      end
    end
  end

  // SPI byte monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      nbits    <= 4'd0;
      byte_idx <= 0;
      hi_cnt   <= 0;
      ss_prev  <= 1'b1;
      sck_prev <= 1'b0;
    end else begin
      ss_prev  <= ss;
      sck_prev <= sck;
      if (!busy) byte_idx <= 0;
      if (!ss && sck_prev && !sck) begin
        sh    <= {sh[6:0], mosi};
        nbits <= nbits + 4'd1;
      end
      if (ss && byte_idx == 1) hi_cnt <= hi_cnt + 1;
      if (ss && !ss_prev) begin
        if (mosi_exp.size() == 0) check("unexpected_byte", 32'd1, 32'd0);
        else check("mosi_byte", {24'd0, sh}, {24'd0, mosi_exp.pop_front()});
        check("bit_count", {28'd0, nbits}, 32'd8);
        check("mosi_idle", {31'd0, mosi}, 32'd0);
        nbits    <= 4'd0;
        byte_idx <= byte_idx + 1;
        hi_cnt   <= 1;
      end
      if (!ss && ss_prev && byte_idx == 1) check("gap_cycles", hi_cnt, GAP_CYC);
    end
  end

  task automatic wb_access(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] exp_dat);
    bit got;
    @(negedge clk);
    mosi_exp.push_back(b0);
    mosi_exp.push_back(b1);
    ack_exp.push_back('{exp_dat, cyc + LAT + 1});
    we = w; addr = a; wdat = d; stb = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    stb = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #12;
    check("rst_ss", {31'd0, ss}, 32'd1);
    check("rst_sck", {31'd0, sck}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", {24'd0, rdat}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    wb_access(1'b1, 8'h05, 8'hA5, 8'h85, 8'hA5, 8'h00);
    wb_access(1'b0, 8'h7F, 8'h00, 8'h7F, 8'h00, 8'h3C);
    wb_access(1'b0, 8'hC2, 8'h00, 8'h42, 8'h00, 8'h3C);
    wb_access(1'b1, 8'h33, 8'h0F, 8'hB3, 8'h0F, 8'h3C);

    // Drop stb during the gap: frame completes, no ack.
    @(negedge clk);
    mosi_exp.push_back(8'h91);
    mosi_exp.push_back(8'h5A);
    we = 1'b1; addr = 8'h11; wdat = 8'h5A; stb = 1'b1;
    repeat (38) @(negedge clk);
    check("in_gap_ss", {31'd0, ss}, 32'd1);
    stb = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    wb_access(1'b0, 8'h7F, 8'h00, 8'h7F, 8'h00, 8'h3C);

    // Reset in the middle of the data byte: only the command byte is seen.
    @(negedge clk);
    mosi_exp.push_back(8'h85);
    we = 1'b1; addr = 8'h05; wdat = 8'hA5; stb = 1'b1;
    repeat (50) @(negedge clk);
    check("mid_data_ss", {31'd0, ss}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ss", {31'd0, ss}, 32'd1);
    check("abort_sck", {31'd0, sck}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ack", {31'd0, ack}, 32'd0);
    stb = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("abort_dat", {24'd0, rdat}, 32'd0);
    repeat (100) @(negedge clk);
    wb_access(1'b0, 8'h05, 8'h00, 8'h05, 8'h00, 8'h3C);

`ifdef SPI_MASTER_LOOPBACK_EN
    begin : lb_test
      int  ss_low;
      bit  got;
      ss_low = 0;
      got = 1'b0;
      @(negedge clk);
      loopback = 1'b1;
      ack_exp.push_back('{8'h00, cyc + LAT + 1});
      we = 1'b0; addr = 8'h10; stb = 1'b1;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        if (!ss) ss_low++;
        if (ack) got = 1'b1;
      end
      if (!got) check("lb_ack_timeout", 32'd0, 32'd1);
      stb = 1'b0;
      check("lb_ss_low", ss_low, 32'd0);
      loopback = 1'b0;
    end
`endif

    repeat (5) @(negedge clk);
    check("ack_queue_empty", ack_exp.size(), 32'd0);
    check("mosi_queue_empty", mosi_exp.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
